decode_stage: RTL
=================

# decode_stage

Instruction-decode stage that feeds the ALU (`alu_top`). It accepts a 32-bit instruction from fetch, decodes it to an instruction ID, and reads the two source registers from an internal 32×32 register file, selecting an immediate where needed. It registers `ir`/`ID`/operand A/operand B into a valid/ready pipeline register that drives the ALU inputs directly. The register-file write port is driven by writeback.

## Interface
Parameters:
- `NREG`, 32: register count. `$0` reads as zero.
- `W`, 32: data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_ir`  in  32  instruction from fetch.
- `in_valid`  in  1  `in_ir` is valid.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `ex_ir`  out  32  registered instruction, goes to ALU `ir`.
- `ex_id`  out  32  registered instruction ID, goes to ALU `ID`.
- `ex_rs`  out  32  operand A (`reg[ir[25:21]]`), goes to ALU `rs`.
- `ex_rt`  out  32  operand B (register or immediate), goes to ALU `rt`.
- `ex_store`  out  32  `reg[ir[20:16]]`, the store data for `sw`.
- `ex_dst`  out  5  destination register.
- `ex_wen`  out  1  instruction writes `ex_dst`.
- `ex_valid`  out  1  pipeline register holds a valid instruction.
- `ex_ready`  in  1  ALU stage accepts `ex_*` this cycle.
- `wb_en`  in  1  register-file write enable.
- `wb_addr`  in  5  write address. Writes to 0 are ignored.
- `wb_data`  in  32  write data.

## Operation
Fields:
- `op = ir[31:26]`, `rs = ir[25:21]`, `rt = ir[20:16]`, `rd = ir[15:11]`, `imm = ir[15:0]`.
- `sext` is `imm` sign-extended to 32 bits; `zext` is `imm` zero-extended.

Decode table (op → ID, operand B, dst, wen):
- `000000` add → 1, `reg[rt]`, `rd`, 1
- `000011` and → 25, `reg[rt]`, `rd`, 1
- `010011` slt → 24, `reg[rt]`, `rd`, 1
- `000001` addi → 5, `sext`, `rt`, 1
- `000110` ori → 10, `zext`, `rt`, 1
- `001000` lw → 13, `sext`, `rt`, 1
- `001001` sw → 14, `sext`, 0, 0
- `010000` j → 21, 0, 0, 0
- any other op → ID 0, operand B 0, dst 0, wen 0 (bubble-like; still passes through the handshake).

Handshake:
- `in_ready = !ex_valid || ex_ready` (combinational).
- Transfer in occurs when `in_valid && in_ready`.
  - The pipeline register loads the decoded values.
  - `ex_valid` is set to 1.
- Otherwise, if `ex_ready` is high, `ex_valid` clears to 0 and the `ex_*` data holds its last value.
- While `ex_valid && !ex_ready` (stall), all `ex_*` outputs stay stable. Operand values are not re-read during the stall.

Register file:
- Written on the rising edge when `wb_en` is high and `wb_addr != 0`.
- Reads are combinational at capture time.
- `reg[0]` always reads 0.

Reset:
- `ex_valid=0` and all `ex_*` outputs are 0.
- All 32 registers are cleared to 0.
- `rst` overrides any transfer or write in the same cycle, including mid-stall; an in-flight instruction is dropped.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented on `ex_*` after edge N.
- Throughput is 1 instruction/cycle when `ex_ready` is held high.
- A write at edge N is visible to reads after edge N.
- Same-cycle write and read of the same register: see Configuration.
- No hazard detection. The upstream/downstream control is responsible for spacing dependent instructions.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - When `wb_en && wb_addr != 0 && wb_addr == read address` in the capture cycle, the operand takes `wb_data` (write-through).
  - Applies to `ex_rs`, to register-sourced `ex_rt`, and to `ex_store`.
- `DECODE_BYPASS_EN` undefined: capture sees the pre-write register value.

## Test plan
- After reset: `ex_valid=0`, all `ex_*` outputs are 0, `in_ready=1`. Reading any register returns 0.
- Write `reg3=10`, `reg5=12`. Present add $1,$3,$5 (`0x00650800`) with `ex_ready=1`.
  - Required next cycle: `ex_id=1`, `ex_rs=10`, `ex_rt=12`, `ex_dst=1`, `ex_wen=1`.
- Write `reg2=10`. Present addi $1,$2,-1 (`0x0441FFFF`).
  - Required: `ex_id=5`, `ex_rs=10`, `ex_rt=0xFFFFFFFF`.
- Present ori $1,$2,0x8000 (`0x18418000`).
  - Required: `ex_rt=0x00008000`, `ex_id=10`.
- Stall: hold `ex_ready=0` for 3 cycles with `in_valid=1`.
  - Required: `in_ready=0` and `ex_*` unchanged throughout.
  - Raising `ex_ready` loads the next instruction on the following edge.
- Same-cycle write and read: `wb_en=1`, `wb_addr=3`, `wb_data=77` in the same cycle as capturing and $1,$3,$6 (`0x0C660800`).
  - Required: `ex_rs=77` with `DECODE_BYPASS_EN` defined, otherwise the old `reg3` value.
  - In both builds `ex_id=25`. Repeat the test with op `111111`: required `ex_id=0`, `ex_wen=0`.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction-decode stage: field decode, 32x32 register file, valid/ready register into the ALU.
// Optional `DECODE_BYPASS_EN: same-cycle writeback data is forwarded to operand reads.
module decode_stage #(
   parameter int NREG = 32,
   parameter int W    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   in_ir,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [31:0]   ex_ir,
   output logic [31:0]   ex_id,
   output logic [W-1:0]  ex_rs,
   output logic [W-1:0]  ex_rt,
   output logic [W-1:0]  ex_store,
   output logic [4:0]    ex_dst,
   output logic          ex_wen,
   output logic          ex_valid,
   input  logic          ex_ready,
   input  logic          wb_en,
   input  logic [4:0]    wb_addr,
   input  logic [W-1:0]  wb_data
);

   logic [W-1:0] r_regs [NREG];

   logic [31:0]  r_ir;
   logic [31:0]  r_id;
   logic [W-1:0] r_rs;
   logic [W-1:0] r_rt;
   logic [W-1:0] r_store;
   logic [4:0]   r_dst;
   logic         r_wen;
   logic         r_valid;

   logic [5:0]   w_op;
   logic [4:0]   w_rs_addr;
   logic [4:0]   w_rt_addr;
   logic [4:0]   w_rd_addr;
   logic [15:0]  w_imm;
   logic [W-1:0] w_sext;
   logic [W-1:0] w_zext;
   logic [W-1:0] w_rs_val;
   logic [W-1:0] w_rt_val;
   logic [31:0]  w_id;
   logic [W-1:0] w_opb;
   logic [4:0]   w_dst;
   logic         w_wen;
   logic         w_xfer;
   logic         w_wb_active;

   assign w_op      = in_ir[31:26];
   assign w_rs_addr = in_ir[25:21];
   assign w_rt_addr = in_ir[20:16];
   assign w_rd_addr = in_ir[15:11];
   assign w_imm     = in_ir[15:0];
   assign w_sext    = {{(W-16){w_imm[15]}}, w_imm};
   assign w_zext    = {{(W-16){1'b0}}, w_imm};

   assign w_wb_active = wb_en && (wb_addr != 5'd0);
   assign in_ready    = !r_valid || ex_ready;
   assign w_xfer      = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wb_active) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   // Register 0 is hard-wired to zero regardless of array contents.
   always_comb begin
      w_rs_val = '0;
      w_rt_val = '0;
      if (w_rs_addr != 5'd0) begin
         w_rs_val = r_regs[w_rs_addr];
`ifdef DECODE_BYPASS_EN
         if (w_wb_active && (wb_addr == w_rs_addr)) w_rs_val = wb_data;
`endif
      end
      if (w_rt_addr != 5'd0) begin
         w_rt_val = r_regs[w_rt_addr];
`ifdef DECODE_BYPASS_EN
         if (w_wb_active && (wb_addr == w_rt_addr)) w_rt_val = wb_data;
`endif
      end
   end

   always_comb begin
      w_id  = 32'd0;
      w_opb = '0;
      w_dst = 5'd0;
      w_wen = 1'b0;
      case (w_op)
         6'b000000: begin w_id = 32'd1;  w_opb = w_rt_val; w_dst = w_rd_addr; w_wen = 1'b1; end
         6'b000011: begin w_id = 32'd25; w_opb = w_rt_val; w_dst = w_rd_addr; w_wen = 1'b1; end
         6'b010011: begin w_id = 32'd24; w_opb = w_rt_val; w_dst = w_rd_addr; w_wen = 1'b1; end
         6'b000001: begin w_id = 32'd5;  w_opb = w_sext;   w_dst = w_rt_addr; w_wen = 1'b1; end
         6'b000110: begin w_id = 32'd10; w_opb = w_zext;   w_dst = w_rt_addr; w_wen = 1'b1; end
         6'b001000: begin w_id = 32'd13; w_opb = w_sext;   w_dst = w_rt_addr; w_wen = 1'b1; end
         6'b001001: begin w_id = 32'd14; w_opb = w_sext;   end
         6'b010000: begin w_id = 32'd21; end
         default:   ;
      endcase
   end

   // Data is only loaded on transfer, so it holds through stalls and after drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ir    <= '0;
         r_id    <= '0;
         r_rs    <= '0;
         r_rt    <= '0;
         r_store <= '0;
         r_dst   <= '0;
         r_wen   <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_xfer) begin
         r_ir    <= in_ir;
         r_id    <= w_id;
         r_rs    <= w_rs_val;
         r_rt    <= w_opb;
         r_store <= w_rt_val;
         r_dst   <= w_dst;
         r_wen   <= w_wen;
         r_valid <= 1'b1;
      end else if (ex_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign ex_ir    = r_ir;
   assign ex_id    = r_id;
   assign ex_rs    = r_rs;
   assign ex_rt    = r_rt;
   assign ex_store = r_store;
   assign ex_dst   = r_dst;
   assign ex_wen   = r_wen;
   assign ex_valid = r_valid;

endmodule
